// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// counter sizing.
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    // Bit-counter width for a given operand width (never narrower than 1 bit).
    function automatic int cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_n_full_adder_cell.sv
// Single-bit full adder assembled from two half-adder cells and an OR gate;
// purely combinational.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    half_adder_cell u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    half_adder_cell u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell with a registered carry
// processes WIDTH bits LSB first, then reports sum/cout with a done pulse.
module serial_adder_n
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int             CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             s_bit;
    logic             c_next;

    full_adder_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s_bit),
        .co (c_next)
    );

    assign res_next = {s_bit, res_sh[WIDTH-1:1]};
    assign busy     = (state == ST_ADD);

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                step = 1'b1;
                if (cnt == LAST_CNT) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: the shift registers are small flops, not RAM, so clearing them on
    // reset is cheap and keeps a reset mid-operation fully deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_sh  <= a;
                b_sh  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
            end else if (step) begin
                a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                res_sh <= res_next;
                carry  <= c_next;
                cnt    <= cnt + 1'b1;
            end
            // Outputs move only on completion, never during the serial pass.
            if (finish) begin
                sum  <= res_next;
                cout <= c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n: directed table at WIDTH=8, multi-cycle
// corner sequences, random sweep, and an exhaustive WIDTH=4 sweep.
module tb_serial_adder_n;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mcin, input logic msub);
        logic [7:0] bb;
        bb = msub ? ~mb : mb;
        return {1'b0, ma} + {1'b0, bb} + {8'd0, (msub ? 1'b1 : mcin)};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] ma, input logic [3:0] mb,
                                          input logic mcin, input logic msub);
        logic [3:0] bb;
        bb = msub ? ~mb : mb;
        return {1'b0, ma} + {1'b0, bb} + {4'd0, (msub ? 1'b1 : mcin)};
    endfunction

    // Starts one WIDTH=8 operation (called at posedge+1), scrambles the inputs
    // after acceptance, and waits (bounded) for done.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                       input logic tsub, output logic [7:0] rs, output logic rc,
                       output int lat, output int busy_cycles, output bit held,
                       output logic done_after);
        logic [7:0] prev_sum;
        logic       prev_cout;
        int k;
        prev_sum = sum8;
        prev_cout = cout8;
        a8 = ta; b8 = tb_v; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_v; cin8 = ~tcin; sub8 = ~tsub;
        k = 0; busy_cycles = 0; held = 1'b1;
        while (!done8 && k < 20) begin
            if (busy8) busy_cycles++;
            if (sum8 !== prev_sum || cout8 !== prev_cout) held = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        lat = k;
        rs = sum8;
        rc = cout8;
        @(posedge clk); #1;
        done_after = done8;
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tcin,
                       input logic tsub, output logic [3:0] rs, output logic rc,
                       output bit timeout);
        int k;
        a4 = ta; b4 = tb_v; cin4 = tcin; sub4 = tsub; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        k = 0;
        while (!done4 && k < 12) begin
            @(posedge clk); #1;
            k++;
        end
        timeout = !done4;
        rs = sum4;
        rc = cout4;
    endtask

    vec_t vecs[8];
    logic [7:0] av[27];
    logic [7:0] bv[27];
    logic       cv[27];
    logic       sv[27];

    initial begin
        logic [7:0] rs;
        logic       rc;
        int         lat;
        int         bc;
        bit         held;
        logic       dn;
        logic [8:0] m;
        int         k;
        int         rand_bad;
        int         exh_bad;

        vecs[0] = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0};
        vecs[5] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
        vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1};

        // Reset state
        #12;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_sum", sum8, 0);
        check("reset_cout", cout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, lat, bc, held, dn);
            check($sformatf("vec%0d_sum", i), rs, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), rc, vecs[i].exp_cout);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_cycles", i), bc, 8);
            check($sformatf("vec%0d_sum_held", i), held, 1);
            check($sformatf("vec%0d_done_one_cycle", i), dn, 0);
        end

        // Start while busy is ignored and not queued
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("busy_start_done_seen", done8, 1);
        check("busy_start_sum", sum8, 8'h33);
        @(posedge clk); #1;
        check("busy_start_not_queued", busy8, 0);

        // Back-to-back with start held high; a/b change every cycle
        start8 = 1'b1;
        for (int c = 0; c < 27; c++) begin
            av[c] = 8'(c * 17 + 3);
            bv[c] = 8'(c * 29 + 5);
            cv[c] = c[0];
            sv[c] = (c % 3 == 0);
            a8 = av[c]; b8 = bv[c]; cin8 = cv[c]; sub8 = sv[c];
            @(posedge clk); #1;
            check($sformatf("b2b_done_c%0d", c), done8, (c % 9 == 8));
            if (c % 9 == 8) begin
                m = model8(av[c-8], bv[c-8], cv[c-8], sv[c-8]);
                check($sformatf("b2b_result_c%0d", c), {cout8, sum8}, m);
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle_after", busy8, 0);

        // Asynchronous reset mid-operation
        check("pre_reset_sum_nonzero", (sum8 != 8'h00 || cout8 != 1'b0), 1);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy8, 0);
        check("midreset_sum", sum8, 0);
        check("midreset_cout", cout8, 0);
        k = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) k++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (done8) k++;
        end
        check("midreset_no_done", k, 0);
        op8(8'h10, 8'h20, 1'b0, 1'b0, rs, rc, lat, bc, held, dn);
        check("postreset_sum", rs, 8'h30);
        check("postreset_cout", rc, 0);

        // Random sweep at WIDTH=8
        rand_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rcin, rsub;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rcin = 1'($urandom);
            rsub = 1'($urandom);
            op8(ra, rb, rcin, rsub, rs, rc, lat, bc, held, dn);
            m = model8(ra, rb, rcin, rsub);
            if ({rc, rs} !== m || lat != 8) rand_bad++;
            check($sformatf("rand%0d", i), {rc, rs, 4'(lat)}, {m, 4'd8});
        end

        // Exhaustive sweep at WIDTH=4
        exh_bad = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int im = 0; im < 4; im++) begin
                    logic [3:0] r4;
                    logic       c4;
                    bit         to;
                    logic [4:0] m4;
                    op4(4'(ia), 4'(ib), im[0], im[1], r4, c4, to);
                    m4 = model4(4'(ia), 4'(ib), im[0], im[1]);
                    check($sformatf("w4_a%0d_b%0d_m%0d", ia, ib, im), {to, c4, r4}, {1'b0, m4});
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
